// File: rtl/game_pkg.sv
// Shared game-state encodings and objective codes used by the sequencer,
// the display mux and the draw_* sub-blocks.
package game_pkg;

   typedef enum logic [3:0] {
      ST_TITLE    = 4'd0,
      ST_STAFF    = 4'd1,
      ST_STAGE1   = 4'd2,
      ST_SUCCESS1 = 4'd3,
      ST_STAGE2   = 4'd4,
      ST_SUCCESS2 = 4'd5,
      ST_STAGE3   = 4'd6,
      ST_SUCCESS3 = 4'd7,
      ST_FAIL     = 4'd8
   } state_t;

   localparam logic [1:0] TODO_KEY  = 2'd0;
   localparam logic [1:0] TODO_DOOR = 2'd1;
   localparam logic [1:0] TODO_BOSS = 2'd2;

   // Clearing a stage always leads to the matching success screen.
   function automatic state_t successOf(input state_t s);
      case (s)
         ST_STAGE1: successOf = ST_SUCCESS1;
         ST_STAGE2: successOf = ST_SUCCESS2;
         default:   successOf = ST_SUCCESS3;
      endcase
   endfunction

endpackage

// File: rtl/game_timer.sv
// Loadable down-counter that stops at zero; used for success-screen hold
// and post-hit invulnerability.
module game_timer #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load_i,
   input  logic [W-1:0] value_i,
   output logic         zero_o
);

   logic [W-1:0] count_q;

   // Load wins over counting so a re-trigger restarts the interval.
   always_ff @(posedge clk) begin
      if (rst) begin
         count_q <= '0;
      end else if (load_i) begin
         count_q <= value_i;
      end else if (count_q != '0) begin
         count_q <= count_q - W'(1);
      end
   end

   assign zero_o = (count_q == '0);

endmodule

// File: rtl/game_fsm.sv
// Top-level game sequencer: stage progression, hearts with invulnerability
// window, timed success screens. All outputs are registered.
module game_fsm
   import game_pkg::*;
#(
   parameter int MAX_HEART     = 3,
   parameter int HEART_W       = 2,
   parameter int SUCCESS_HOLD  = 100_000_000,
   parameter int INVULN_CYCLES = 50_000_000
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               btn_start,
   input  logic               btn_staff,
   input  logic               key_hit,
   input  logic               door_hit,
   input  logic               damage,
   input  logic               boss_dead,
   output logic [3:0]         state,
   output logic [HEART_W-1:0] heart,
   output logic               key_find,
   output logic               isLocked,
   output logic [1:0]         todo,
   output logic               play_valid
);

   localparam int HOLD_W = (SUCCESS_HOLD > 2) ? $clog2(SUCCESS_HOLD) : 1;
   localparam int INV_W  = $clog2(INVULN_CYCLES + 1);

   state_t             state_q;
   logic [HEART_W-1:0] heart_q;
   logic               key_q, locked_q, boss_q, play_q;
   logic [1:0]         todo_q;

   logic inStage, isStage3, doorOpen, doorOk, hitCounted, fatal;
   logic inHold, stageEntry, keyNext, bossNext;
   logic holdZero, invZero;

   assign inStage  = (state_q == ST_STAGE1) || (state_q == ST_STAGE2) || (state_q == ST_STAGE3);
   assign isStage3 = (state_q == ST_STAGE3);
   assign inHold   = (state_q == ST_SUCCESS1) || (state_q == ST_SUCCESS2);

   // Door state comes from registered progress only, so a same-cycle key
   // pickup cannot open the door for that cycle's door_hit.
   assign doorOpen   = key_q & (~isStage3 | boss_q);
   assign doorOk     = inStage & door_hit & doorOpen;
   assign hitCounted = inStage & damage & invZero;
   assign fatal      = hitCounted & (heart_q <= HEART_W'(1));
   assign stageEntry = ((state_q == ST_TITLE) & btn_start) | (inHold & holdZero);
   assign keyNext    = key_q | key_hit;
   assign bossNext   = boss_q | (isStage3 & boss_dead);

   game_timer #(.W(HOLD_W)) uHold (
      .clk     (clk),
      .rst     (rst),
      .load_i  (doorOk & ~fatal),
      .value_i (HOLD_W'(SUCCESS_HOLD - 1)),
      .zero_o  (holdZero)
   );

   game_timer #(.W(INV_W)) uInvuln (
      .clk     (clk),
      .rst     (rst),
      .load_i  (stageEntry | hitCounted),
      .value_i (hitCounted ? INV_W'(INVULN_CYCLES) : '0),
      .zero_o  (invZero)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= ST_TITLE;
         heart_q  <= '0;
         key_q    <= 1'b0;
         locked_q <= 1'b1;
         todo_q   <= TODO_KEY;
         boss_q   <= 1'b0;
         play_q   <= 1'b0;
      end else begin
         case (state_q)
            ST_TITLE: begin
               if (btn_start) begin
                  state_q  <= ST_STAGE1;
                  heart_q  <= HEART_W'(MAX_HEART);
                  key_q    <= 1'b0;
                  locked_q <= 1'b1;
                  todo_q   <= TODO_KEY;
                  boss_q   <= 1'b0;
                  play_q   <= 1'b1;
               end else if (btn_staff) begin
                  state_q <= ST_STAFF;
               end
            end
            ST_STAFF: begin
               if (btn_start || btn_staff) begin
                  state_q <= ST_TITLE;
               end
            end
            ST_STAGE1, ST_STAGE2, ST_STAGE3: begin
               key_q    <= keyNext;
               boss_q   <= bossNext;
               locked_q <= ~(keyNext & (~isStage3 | bossNext));
               if (!keyNext) begin
                  todo_q <= TODO_KEY;
               end else if (isStage3 && !bossNext) begin
                  todo_q <= TODO_BOSS;
               end else begin
                  todo_q <= TODO_DOOR;
               end
               // Fatal damage outranks a simultaneous valid door entry.
               if (fatal) begin
                  heart_q <= '0;
                  state_q <= ST_FAIL;
                  play_q  <= 1'b0;
               end else begin
                  if (hitCounted) begin
                     heart_q <= heart_q - HEART_W'(1);
                  end
                  if (doorOk) begin
                     state_q <= successOf(state_q);
                     play_q  <= 1'b0;
                  end
               end
            end
            ST_SUCCESS1, ST_SUCCESS2: begin
               if (holdZero) begin
                  state_q  <= (state_q == ST_SUCCESS1) ? ST_STAGE2 : ST_STAGE3;
                  key_q    <= 1'b0;
                  locked_q <= 1'b1;
                  todo_q   <= TODO_KEY;
                  boss_q   <= 1'b0;
                  play_q   <= 1'b1;
               end
            end
            ST_SUCCESS3, ST_FAIL: begin
               if (btn_start) begin
                  state_q  <= ST_TITLE;
                  heart_q  <= '0;
                  key_q    <= 1'b0;
                  locked_q <= 1'b1;
                  todo_q   <= TODO_KEY;
                  boss_q   <= 1'b0;
                  play_q   <= 1'b0;
               end
            end
            default: begin
               state_q  <= ST_TITLE;
               heart_q  <= '0;
               key_q    <= 1'b0;
               locked_q <= 1'b1;
               todo_q   <= TODO_KEY;
               boss_q   <= 1'b0;
               play_q   <= 1'b0;
            end
         endcase
      end
   end

   assign state      = state_q;
   assign heart      = heart_q;
   assign key_find   = key_q;
   assign isLocked   = locked_q;
   assign todo       = todo_q;
   assign play_valid = play_q;

endmodule
